// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b computed LSB first, one bit per clock, behind a start/busy/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic [WIDTH-2:0] partial;
   logic             borrow;
   logic [CNT_W-1:0] cnt;

   logic             a0;
   logic             b0;
   logic             d;
   logic             bw_next;
   logic             last_bit;
   logic [WIDTH-1:0] full_next;

   // Half-subtractor cell plus borrow-in on the current LSBs
   always_comb begin
      a0        = shift_a[0];
      b0        = shift_b[0];
      d         = a0 ^ b0 ^ borrow;
      bw_next   = (~a0 & b0) | (~(a0 ^ b0) & borrow);
      last_bit  = (cnt == LAST_BIT);
      full_next = {d, partial};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Partial result fills from the top; on the final bit the new d plus
   // the WIDTH-1 accumulated bits form the complete difference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_a    <= '0;
         shift_b    <= '0;
         partial    <= '0;
         borrow     <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         ovf        <= 1'b0;
`endif
      end else if (state == IDLE && start) begin
         shift_a <= a;
         shift_b <= b;
         borrow  <= 1'b0;
         cnt     <= '0;
      end else if (state == RUN) begin
         shift_a <= shift_a >> 1;
         shift_b <= shift_b >> 1;
         partial <= full_next[WIDTH-1:1];
         borrow  <= bw_next;
         cnt     <= cnt + CNT_W'(1);
         if (last_bit) begin
            diff       <= full_next;
            borrow_out <= bw_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf        <= (a0 != b0) && (d != a0);
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed steps, reference model
// results queued at each accepted start and compared when done pulses.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             ovf;
`endif

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             borrow;
      logic             ovf;
   } exp_t;

   exp_t             expQ[$];
   int               nAsserts = 0;
   int               nFails = 0;
   logic [WIDTH-1:0] lastDiff;
   logic             lastBorrow;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
      ,
      .ovf        (ovf)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nAsserts++;
      assert (obs === expv)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      exp_t e;
      e.diff   = x - y;
      e.borrow = (x < y);
      e.ovf    = (x[WIDTH-1] != y[WIDTH-1]) && (e.diff[WIDTH-1] != x[WIDTH-1]);
      return e;
   endfunction

   task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input bit expectResult, input bit scramble);
      @(negedge clk);
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (expectResult) expQ.push_back(model(x, y));
      start = 1'b0;
      if (scramble) begin
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
      end
   endtask

   task automatic waitDone(input string tag, input int skipped);
      int   n;
      int   busyCnt;
      int   unstable;
      exp_t e;
      n        = skipped;
      busyCnt  = skipped;
      unstable = 0;
      do begin
         @(negedge clk);
         n++;
         if (busy === 1'b1) busyCnt++;
         if (done !== 1'b1 && (diff !== lastDiff || borrow_out !== lastBorrow)) unstable++;
      end while (done !== 1'b1 && n < 4 * WIDTH);
      checkOutput({tag, " done seen"}, done, 1);
      checkOutput({tag, " latency"}, n, WIDTH + 1);
      checkOutput({tag, " busy cycles"}, busyCnt, WIDTH);
      checkOutput({tag, " old result held"}, unstable, 0);
      if (expQ.size() == 0) begin
         checkOutput({tag, " scoreboard entry"}, 0, 1);
      end else begin
         e = expQ.pop_front();
         checkOutput({tag, " diff"}, diff, e.diff);
         checkOutput({tag, " borrow_out"}, borrow_out, e.borrow);
`ifdef SERIAL_SUB_OVERFLOW_EN
         checkOutput({tag, " ovf"}, ovf, e.ovf);
`endif
         lastDiff   = e.diff;
         lastBorrow = e.borrow;
      end
      @(negedge clk);
      checkOutput({tag, " done pulse width"}, done, 0);
      checkOutput({tag, " busy after done"}, busy, 0);
      checkOutput({tag, " diff held after done"}, diff, lastDiff);
   endtask

   task automatic noDone(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done !== 1'b0) pulses++;
      end
      checkOutput({tag, " no done pulse"}, pulses, 0);
      checkOutput({tag, " idle"}, busy, 0);
   endtask

   initial begin
      rst_n      = 1'b1;
      start      = 1'b0;
      a          = '0;
      b          = '0;
      lastDiff   = '0;
      lastBorrow = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset diff", diff, 0);
      checkOutput("reset borrow_out", borrow_out, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      checkOutput("reset ovf", ovf, 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(8'h35, 8'h12, 1'b1, 1'b1);
      waitDone("35-12", 0);

      applyStimulus(8'h12, 8'h35, 1'b1, 1'b1);
      waitDone("12-35", 0);
      applyStimulus(8'h00, 8'h01, 1'b1, 1'b1);
      waitDone("00-01", 0);

      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
      waitDone("FF-FF", 0);
      applyStimulus(8'hA5, 8'h00, 1'b1, 1'b1);
      waitDone("A5-00", 0);

      // A second start during RUN must be ignored.
      applyStimulus(8'h50, 8'h20, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("ignored start busy", busy, 1);
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h01;
      @(negedge clk);
      a = 8'h7E;
      b = 8'h3C;
      @(negedge clk);
      start = 1'b0;
      waitDone("50-20 with ignored start", 3);
      noDone("after ignored start", WIDTH + 4);
      checkOutput("scoreboard empty after ignored start", expQ.size(), 0);

      // Reset in the middle of RUN aborts the operation.
      applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort done", done, 0);
      checkOutput("abort diff", diff, 0);
      checkOutput("abort borrow_out", borrow_out, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      checkOutput("abort ovf", ovf, 0);
`endif
      lastDiff   = '0;
      lastBorrow = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      noDone("after abort", WIDTH + 4);
      applyStimulus(8'h80, 8'h01, 1'b1, 1'b1);
      waitDone("80-01", 0);

      // Start held high: second operation accepted WIDTH+2 cycles after the first.
      @(negedge clk);
      a     = 8'hC3;
      b     = 8'h3C;
      start = 1'b1;
      @(posedge clk);
      #1;
      expQ.push_back(model(8'hC3, 8'h3C));
      a = 8'h10;
      b = 8'h20;
      waitDone("b2b op1", 0);
      @(posedge clk);
      #1;
      expQ.push_back(model(8'h10, 8'h20));
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      waitDone("b2b op2", 0);
      checkOutput("scoreboard empty at end", expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
